// File: rtl/wb_arb_pkg.sv
// Shared types and default widths for the
// two-master Wishbone memory arbiter.
package wb_arb_pkg;

  localparam int ADR_W = 12;
  localparam int DAT_W = 128;
  localparam int SEL_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } state_t;

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// One Wishbone link; master modport is the side
// that drives cyc/stb, slave modport answers.
interface wb_mem_arbiter_if #(
  parameter int ADR_W = wb_arb_pkg::ADR_W,
  parameter int DAT_W = wb_arb_pkg::DAT_W,
  parameter int SEL_W = wb_arb_pkg::SEL_W
) ();

  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_m;
  logic [SEL_W-1:0] sel;
  logic [DAT_W-1:0] dat_s;
  logic             ack;
  logic             rty;

  modport master (
    output cyc, stb, we, adr, dat_m, sel,
    input  dat_s, ack, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_m, sel,
    output dat_s, ack, rty
  );

endinterface

// File: rtl/wb_arb_pick.sv
// Two-way round-robin pick: on a tie the master
// that did not hold the last grant wins.
module wb_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_idx
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = req1 & (~req0 | ~last_gnt);
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Shares the memory Wishbone port between the
// icache (m0) and dcache (m1), one owner per cycle.
module wb_mem_arbiter
  import wb_arb_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  wb_mem_arbiter_if.slave  m0,
  wb_mem_arbiter_if.slave  m1,
  wb_mem_arbiter_if.master s
);

  state_t state;
  state_t state_n;
  logic   last_gnt;
  logic   req0;
  logic   req1;
  logic   pick_vld;
  logic   pick_idx;
  state_t pick_st;

  assign req0 = m0.cyc & m0.stb;
  assign req1 = m1.cyc & m1.stb;

  wb_arb_pick u_pick (
    .req0      (req0),
    .req1      (req1),
    .last_gnt  (last_gnt),
    .gnt_valid (pick_vld),
    .gnt_idx   (pick_idx)
  );

  // last_gnt equals the owner while granted, so the
  // same pick prefers the other master on hand-off
  assign pick_st = !pick_vld ? IDLE
                 : pick_idx  ? GNT1
                 :             GNT0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_n;
      if (state_n == GNT0) last_gnt <= 1'b0;
      if (state_n == GNT1) last_gnt <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = pick_st;
      GNT0: begin
        if (s.ack)        state_n = pick_st;
        else if (!m0.cyc) state_n = IDLE;
      end
      GNT1: begin
        if (s.ack)        state_n = pick_st;
        else if (!m1.cyc) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign m0.dat_s = s.dat_s;
  assign m1.dat_s = s.dat_s;

  always_comb begin
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    s.adr   = '0;
    s.dat_m = '0;
    s.sel   = '0;
    m0.ack  = 1'b0;
    m0.rty  = 1'b0;
    m1.ack  = 1'b0;
    m1.rty  = 1'b0;
    unique case (state)
      GNT0: begin
        s.cyc   = m0.cyc;
        s.stb   = m0.stb;
        s.we    = m0.we;
        s.adr   = m0.adr;
        s.dat_m = m0.dat_m;
        s.sel   = m0.sel;
        m0.ack  = s.ack;
        m0.rty  = s.rty;
      end
      GNT1: begin
        s.cyc   = m1.cyc;
        s.stb   = m1.stb;
        s.we    = m1.we;
        s.adr   = m1.adr;
        s.dat_m = m1.dat_m;
        s.sel   = m1.sel;
        m1.ack  = s.ack;
        m1.rty  = s.rty;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter sharing the physical memory port between a split instruction cache (master 0) and data cache (master 1).
- Sits between the two cache memory-side ports and the top-level memory interface.
- Registered round-robin grant; per-transaction ownership; combinational forwarding while granted.

Parameters:
ADR_W, 12, line address width (16-bit byte address minus 4 offset bits)
DAT_W, 128, cache line data width
SEL_W, 16, byte-select width (DAT_W/8)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
m0_cyc, m0_stb, m0_we  in  1 each  master 0 (icache) cycle/strobe/write
m0_adr  in  ADR_W  master 0 address
m0_dat_m  in  DAT_W  master 0 write data
m0_sel  in  SEL_W  master 0 byte selects
m0_dat_s  out  DAT_W  read data to master 0
m0_ack, m0_rty  out  1 each  ack/retry to master 0
m1_*  same set as m0_*  master 1 (dcache)
s_cyc, s_stb, s_we  out  1 each  to memory
s_adr  out  ADR_W  to memory
s_dat_m  out  DAT_W  to memory
s_sel  out  SEL_W  to memory
s_dat_s  in  DAT_W  memory read data
s_ack, s_rty  in  1 each  memory ack/retry

Behaviour:
- reqN = mN_cyc & mN_stb. States: IDLE, GNT0, GNT1 (registered). last_gnt bit (registered).
- Reset (async, immediate): state=IDLE, last_gnt=1 (master 0 wins first tie). s_cyc=s_stb=s_we=0, s_adr/s_dat_m/s_sel=0, m0/m1 ack=rty=0.
- IDLE: all s_* outputs 0. Next: only req0 -> GNT0; only req1 -> GNT1; both -> grant to master != last_gnt; none -> IDLE. Grant-decision latency 1 cycle: request seen in cycle N, s_cyc/s_stb asserted in cycle N+1.
- GNTx: s_cyc/s_stb/s_we/s_adr/s_dat_m/s_sel = master x's signals combinationally; mx_ack=s_ack, mx_rty=s_rty; other master's ack/rty=0. On entry, last_gnt<=x.
- GNTx on s_ack: transaction done. Next: other master requesting -> GNTy (direct hand-off, no idle cycle); else x still requesting (new cycle) -> GNTx; else IDLE.
- GNTx on s_rty: forwarded; grant retained while mx_cyc stays high, master re-strobes.
- GNTx with mx_cyc low and no s_ack (abort): -> IDLE next cycle; s_cyc follows mx_cyc, so it drops the same cycle.
- s_dat_s broadcast to both m0_dat_s and m1_dat_s unconditionally; only ack qualifies it.
- s_ack and s_rty both high: treat as ack; rty forwarded unchanged.
- Non-granted master sees ack=rty=0 indefinitely and must hold its request; no starvation, since round-robin bounds wait to one transaction.
- RST mid-transaction: outputs drop immediately; pending masters re-arbitrate after release (master 0 first on tie).

Decomposition:
- Package wb_arb_pkg: state enum (IDLE, GNT0, GNT1), ADR_W/DAT_W/SEL_W default constants.
- One sub-module: wb_arb_pick (combinational 2-way round-robin pick from req0, req1, last_gnt -> gnt_valid, gnt_idx), reused by IDLE and ack hand-off logic.

Test Plan:
- Reset then req0 only, read adr 0x010, slave acks with data 0xDEAD...BEEF after 3 cycles -> s_cyc high 1 cycle after req, m0_ack pulses 1 cycle with m0_dat_s = data, m1_ack=0, then IDLE.
- req0 and req1 asserted same cycle after reset -> GNT0 first; on ack, GNT1 next cycle with no idle gap; s_adr switches from m0_adr=0x100 to m1_adr=0x200.
- Both masters continuously requesting, 6 transactions -> grants alternate 0,1,0,1,0,1; no master waits over one transaction.
- Master 1 write, slave asserts s_rty twice then s_ack -> m1_rty pulses twice, grant held throughout, s_we=1, s_sel=0xFFFF, m0 stays blocked until ack.
- Assert RST mid-GNT1 with s_stb high -> s_cyc/s_stb/m1_ack fall asynchronously before next edge; after release with both requesting -> GNT0.
- Master 0 drops cyc before ack (abort) -> s_cyc falls same cycle, state IDLE next cycle, pending req1 granted the cycle after.
